// File: rtl/pe_control_sequencer_if.sv
// Host/core-side signal bundle for the PE control sequencer.
// The master modport is the host/environment side; the slave modport is the sequencer.
interface pe_control_sequencer_if #(
  parameter int NUM_INPUT_CHANNELS  = 4,
  parameter int NUM_OUTPUT_CHANNELS = 4,
  parameter int CYCLE_COUNTER_WIDTH = 32
);
  logic                           enable;
  logic                           execute;
  logic                           core_halted;
  logic [NUM_INPUT_CHANNELS-1:0]  input_channel_empty;
  logic [NUM_OUTPUT_CHANNELS-1:0] output_channel_empty;
  logic                           router_buffers_empty;
  logic                           core_reset;
  logic                           core_enable;
  logic                           core_execute;
  logic                           halted;
  logic                           channels_quiescent;
  logic                           router_quiescent;
  logic                           done;
  logic [1:0]                     state;
  logic [CYCLE_COUNTER_WIDTH-1:0] run_cycle_count;

  modport master (
    output enable, execute, core_halted, input_channel_empty,
           output_channel_empty, router_buffers_empty,
    input  core_reset, core_enable, core_execute, halted, channels_quiescent,
           router_quiescent, done, state, run_cycle_count
  );

  modport slave (
    input  enable, execute, core_halted, input_channel_empty,
           output_channel_empty, router_buffers_empty,
    output core_reset, core_enable, core_execute, halted, channels_quiescent,
           router_quiescent, done, state, run_cycle_count
  );
endinterface

// File: rtl/pe_control_sequencer.sv
// PE control/status sequencer: retimes host reset/enable/execute, filters
// channel/router quiescence and tracks the IDLE/RUN/DRAIN/DONE run lifecycle.
module pe_control_sequencer #(
  parameter int CONTROL_PIPELINE_DEPTH = 1,
  parameter int NUM_INPUT_CHANNELS     = 4,
  parameter int NUM_OUTPUT_CHANNELS    = 4,
  parameter int QUIESCENCE_HOLD_CYCLES = 4,
  parameter int CYCLE_COUNTER_WIDTH    = 32
) (
  input logic                  clock,
  input logic                  reset,
  pe_control_sequencer_if.slave bus
);
  localparam int D      = CONTROL_PIPELINE_DEPTH;
  localparam int HW_RAW = $clog2(QUIESCENCE_HOLD_CYCLES + 1);
  localparam int HW     = (HW_RAW > 3) ? HW_RAW : 3;
  localparam logic [HW-1:0] HOLD = HW'(QUIESCENCE_HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  logic [NUM_INPUT_CHANNELS-1:0]  ice;
  logic [NUM_OUTPUT_CHANNELS-1:0] oce;
  logic [D-1:0] rst_pipe_q, rst_pipe_d;
  logic [D-1:0] en_pipe_q, en_pipe_d;
  logic [D-1:0] ex_pipe_q, ex_pipe_d;
  logic         en_p, ex_p;
  logic         halted_q, halted_d;
  logic [1:0]   cond;
  logic [1:0]   quiet;
  state_e       state_q, state_d;
  logic         core_execute_q, core_execute_d;
  logic [CYCLE_COUNTER_WIDTH-1:0] count_q, count_d;

  assign ice  = bus.input_channel_empty;
  assign oce  = bus.output_channel_empty;
  assign en_p = en_pipe_q[D-1];
  assign ex_p = ex_pipe_q[D-1];

  // Shift the control pipelines by one stage; stage 0 takes the host pins.
  always_comb begin
    rst_pipe_d    = '0;
    en_pipe_d     = '0;
    ex_pipe_d     = '0;
    en_pipe_d[0]  = bus.enable;
    ex_pipe_d[0]  = bus.execute;
    for (int i = 1; i < D; i++) begin
      rst_pipe_d[i] = rst_pipe_q[i-1];
      en_pipe_d[i]  = en_pipe_q[i-1];
      ex_pipe_d[i]  = ex_pipe_q[i-1];
    end
  end

  // Reset fills the reset pipeline with ones and flushes enable/execute.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_pipe_q <= '1;
      en_pipe_q  <= '0;
      ex_pipe_q  <= '0;
    end else begin
      rst_pipe_q <= rst_pipe_d;
      en_pipe_q  <= en_pipe_d;
      ex_pipe_q  <= ex_pipe_d;
    end
  end

  // Halt flag from the core, registered once.
  always_comb halted_d = bus.core_halted;

  // Halt flag register.
  always_ff @(posedge clock) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  // Index 0 is the channel filter, index 1 the router filter.
  assign cond = {bus.router_buffers_empty, (&ice) & (&oce)};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filter
      logic [HW-1:0] hold_cnt_q, hold_cnt_d;
      logic          quiet_q, quiet_d;

      // Count consecutive condition cycles, saturating at the hold-off; the
      // flag needs the counter already at the hold-off plus the condition now.
      always_comb begin
        hold_cnt_d = '0;
        if (cond[gi]) hold_cnt_d = (hold_cnt_q == HOLD) ? hold_cnt_q : hold_cnt_q + HW'(1);
        quiet_d = cond[gi] && (hold_cnt_q == HOLD);
      end

      // Filter state registers; independent of enable and run state.
      always_ff @(posedge clock) begin
        if (reset) begin
          hold_cnt_q <= '0;
          quiet_q    <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_d;
          quiet_q    <= quiet_d;
        end
      end

      assign quiet[gi] = quiet_q;
    end
  endgenerate

  // Lifecycle state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; only advances on cycles where the retimed enable is high.
  always_comb begin
    state_d = state_q;
    if (en_p) begin
      case (state_q)
        S_IDLE:  if (ex_p) state_d = S_RUN;
        S_RUN:   if (halted_q) state_d = S_DRAIN;
                 else if (!ex_p) state_d = S_IDLE;
        S_DRAIN: if (quiet[0] && quiet[1]) state_d = S_DONE;
                 else if (!ex_p) state_d = S_IDLE;
        default: state_d = S_DONE;
      endcase
    end
  end

  // Registered outputs: execute decode and saturating run counter, both frozen while disabled.
  always_comb begin
    core_execute_d = core_execute_q;
    count_d        = count_q;
    if (en_p) begin
      core_execute_d = (state_q == S_RUN);
      if ((state_q == S_RUN || state_q == S_DRAIN) && count_q != '1)
        count_d = count_q + CYCLE_COUNTER_WIDTH'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      core_execute_q <= 1'b0;
      count_q        <= '0;
    end else begin
      core_execute_q <= core_execute_d;
      count_q        <= count_d;
    end
  end

  assign bus.core_reset         = rst_pipe_q[D-1];
  assign bus.core_enable        = en_p;
  assign bus.core_execute       = core_execute_q;
  assign bus.halted             = halted_q;
  assign bus.channels_quiescent = quiet[0];
  assign bus.router_quiescent   = quiet[1];
  assign bus.done               = (state_q == S_DONE);
  assign bus.state              = state_q;
  assign bus.run_cycle_count    = count_q;
endmodule
